instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: PC_W, 8, program counter and instruction-memory address width.
REQ-002 Parameter: MUL_CYC, 2, total EXEC cycles for mul opcode (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse; begins execution at start_pc.
REQ-006 start_pc  input  PC_W  first instruction address.
REQ-007 imem_rd_en  output  1  instruction-memory read strobe.
REQ-008 imem_addr  output  PC_W  instruction-memory address.
REQ-009 imem_rdata  input  32  instruction word, valid exactly one cycle after imem_rd_en.
REQ-010 ir  output  32  instruction register driven to GPR datapath (op[31:27], rdst[26:22], rsrc1[21:17], mode[16], rsrc2[15:11], imm[15:0]).
REQ-011 exec_en  output  1  datapath commit strobe; GPR/SGPR write only while high.
REQ-012 busy  output  1  high in any state except IDLE and HALT.
REQ-013 halted  output  1  high in HALT.
REQ-014 illegal  output  1  sticky illegal-opcode flag.
REQ-015 retired  output  16  count of committed instructions.
REQ-016 pc  output  PC_W  current program counter.

Function
REQ-017 FSM states: IDLE, FETCH, LOAD, EXEC, HALT.
REQ-018 IDLE or HALT + start: pc<=start_pc, retired<=0, illegal<=0, next FETCH; start in any other state is ignored.
REQ-019 FETCH: imem_rd_en=1, imem_addr=pc for exactly one cycle; next LOAD.
REQ-020 LOAD: ir<=imem_rdata; decode imem_rdata[31:27]: 00000..00100 -> EXEC; 11111 (halt) -> HALT; any other -> illegal<=1, HALT.
REQ-021 Halt and illegal instructions never assert exec_en, never increment retired, and leave pc pointing at the offending word.
REQ-022 EXEC for movsgpr/mov/add/sub: one cycle, exec_en=1.
REQ-023 EXEC for mul: MUL_CYC cycles; exec_en=1 only in the final cycle (single commit, no re-accumulation).
REQ-024 Final EXEC cycle: pc<=pc+1 modulo 2^PC_W (wraps max->0), retired<=retired+1 saturating at 16'hFFFF, next FETCH.
REQ-025 exec_en is never high for more than one consecutive cycle per instruction.
REQ-026 Latency: non-mul instruction 3 cycles, mul 2+MUL_CYC cycles, start-to-first-commit 4 cycles (non-mul).
REQ-027 ir holds its value outside LOAD; retains last instruction in HALT.

Reset
REQ-028 rst_n low: state IDLE, pc=0, ir=0, retired=0, illegal=0, exec_en=0, imem_rd_en=0, busy=0, halted=0, immediately and independent of clk.
REQ-029 Reset during EXEC (including mid-mul) de-asserts exec_en at once; no commit occurs.
REQ-030 First active state update occurs on the first rising clk after rst_n rises.

Structure
REQ-031 Package instr_seq_pkg holds: opcode constants (MOVSGPR 00000, MOV 00001, ADD 00010, SUB 00011, MUL 00100, HALT 11111), IR field bit positions, FSM state enum.
REQ-032 One combinational sub-module instr_decode (opcode -> is_legal, is_mul, is_halt) shared with the datapath.

Verification
REQ-033 Program {mov r1,#5; add r2,r1,#3; halt} at 0: exec_en pulses at cycles 4 and 7, retired=2, halted=1, pc=2.
REQ-034 mul with MUL_CYC=3: exactly one exec_en pulse, in the 3rd EXEC cycle; instruction takes 5 cycles.
REQ-035 Opcode 01010 at address 3: illegal=1, halted=1, pc=3, no exec_en; next start clears illegal.
REQ-036 PC_W=4, start_pc=15, non-halt word at 15: pc wraps to 0 and fetch continues from address 0.
REQ-037 rst_n low mid-mul EXEC: exec_en, busy drop without clk edge; all outputs at reset values.
REQ-038 start pulsed while busy: ignored, pc sequence unchanged.

Source files
------------

// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, IR field positions
// and the control FSM state encoding.
package instr_seq_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned RET_W   = 16;

  // Instruction register field positions
  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 27;
  localparam int unsigned RDST_MSB  = 26;
  localparam int unsigned RDST_LSB  = 22;
  localparam int unsigned RSRC1_MSB = 21;
  localparam int unsigned RSRC1_LSB = 17;
  localparam int unsigned MODE_BIT  = 16;
  localparam int unsigned RSRC2_MSB = 15;
  localparam int unsigned RSRC2_LSB = 11;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned IMM_LSB   = 0;

  localparam logic [OPC_W-1:0] OPC_MOVSGPR = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_MOV     = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ADD     = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_SUB     = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_MUL     = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_HALT    = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/instr_decode.sv
// Opcode classifier shared by the sequencer and the GPR datapath.
module instr_decode
  import instr_seq_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             is_legal,
  output logic             is_mul,
  output logic             is_halt
);

  // Executable opcodes occupy the contiguous range movsgpr..mul
  assign is_mul   = (opcode == OPC_MUL);
  assign is_halt  = (opcode == OPC_HALT);
  assign is_legal = (opcode <= OPC_MUL) || is_halt;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/load/execute control sequencer: walks instruction memory from start_pc,
// holds the instruction register and strobes a single datapath commit per instruction.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned MUL_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  output logic               imem_rd_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               exec_en,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic [RET_W-1:0]   retired,
  output logic [PC_W-1:0]    pc
);

  localparam int unsigned CNT_W = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYC - 1);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [RET_W-1:0]   retired_q, retired_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               exec_en_q, exec_en_d;
  logic               rd_en_q, rd_en_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;

  logic dec_legal, dec_mul, dec_halt;

  instr_decode u_decode (
    .opcode   (imem_rdata[OP_MSB:OP_LSB]),
    .is_legal (dec_legal),
    .is_mul   (dec_mul),
    .is_halt  (dec_halt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      exec_en_q <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      exec_en_q <= exec_en_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  // Next-state logic; strobes are derived from the next state so they register in step with it
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d      = start_pc;
          retired_d = '0;
          illegal_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        ir_d = imem_rdata;
        if (dec_halt) begin
          state_d = S_HALT;
        end else if (dec_legal) begin
          cnt_d   = dec_mul ? MUL_LAST : '0;
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        // cnt_q counts remaining mul cycles; zero marks the commit cycle
        if (cnt_q == '0) begin
          pc_d      = pc_q + PC_W'(1);
          retired_d = (retired_q == '1) ? retired_q : retired_q + RET_W'(1);
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_en_d   = (state_d == S_FETCH);
    exec_en_d = (state_d == S_EXEC) && (cnt_d == '0);
    busy_d    = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d  = (state_d == S_HALT);
  end

  assign imem_rd_en = rd_en_q;
  assign imem_addr  = pc_q;
  assign ir         = ir_q;
  assign exec_en    = exec_en_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;
  assign retired    = retired_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: one 8-bit-PC instance with a 3-cycle mul
// and one 4-bit-PC instance for address wrap, each with its own instruction memory.
module tb_instr_sequencer;

  localparam logic [31:0] MOV_W  = 32'h0841_0005; // mov r1,#5
  localparam logic [31:0] ADD_W  = 32'h1083_0003; // add r2,r1,#3
  localparam logic [31:0] MUL_W  = 32'h20C4_0800; // mul r3,r2,r1
  localparam logic [31:0] ILL_W  = 32'h5000_0000; // opcode 01010
  localparam logic [31:0] HALT_W = 32'hF800_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        start_a = 1'b0;
  logic [7:0]  start_pc_a = '0;
  logic        rd_en_a, exec_en_a, busy_a, halted_a, illegal_a;
  logic [7:0]  addr_a, pc_a;
  logic [31:0] rdata_a = '0;
  logic [31:0] ir_a;
  logic [15:0] retired_a;
  logic [31:0] mem_a [256];

  logic        start_b = 1'b0;
  logic [3:0]  start_pc_b = '0;
  logic        rd_en_b, exec_en_b, busy_b, halted_b, illegal_b;
  logic [3:0]  addr_b, pc_b;
  logic [31:0] rdata_b = '0;
  logic [31:0] ir_b;
  logic [15:0] retired_b;
  logic [31:0] mem_b [16];

  instr_sequencer #(.PC_W(8), .MUL_CYC(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .start_pc(start_pc_a),
    .imem_rd_en(rd_en_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
    .ir(ir_a), .exec_en(exec_en_a), .busy(busy_a), .halted(halted_a),
    .illegal(illegal_a), .retired(retired_a), .pc(pc_a)
  );

  instr_sequencer #(.PC_W(4), .MUL_CYC(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .start_pc(start_pc_b),
    .imem_rd_en(rd_en_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
    .ir(ir_b), .exec_en(exec_en_b), .busy(busy_b), .halted(halted_b),
    .illegal(illegal_b), .retired(retired_b), .pc(pc_b)
  );

  // Synchronous memories: data returns one cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= mem_a[addr_a];
    if (rd_en_b) rdata_b <= mem_b[addr_b];
  end

  // Start pulse occupies cycle 1; returns at the sample point of cycle 2
  task automatic kick_a(input logic [7:0] spc);
    @(negedge clk);
    start_pc_a = spc;
    start_a    = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
  endtask

  task automatic kick_b(input logic [3:0] spc);
    @(negedge clk);
    start_pc_b = spc;
    start_b    = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
  endtask

  // Records per-cycle strobes of instance A for cycles 2..last_c
  task automatic trace_a(input int last_c, output logic [31:0] ex_m,
                         output logic [31:0] rd_m, output logic [31:0] bz_m);
    ex_m = '0;
    rd_m = '0;
    bz_m = '0;
    for (int c = 2; c <= last_c; c++) begin
      ex_m[c] = exec_en_a;
      rd_m[c] = rd_en_a;
      bz_m[c] = busy_a;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({pc_a, ir_a, retired_a, illegal_a, exec_en_a, rd_en_a, busy_a, halted_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got pc=%0h ir=%0h ret=%0d ill=%b ex=%b rd=%b busy=%b halt=%b, want all zero",
               pc_a, ir_a, retired_a, illegal_a, exec_en_a, rd_en_a, busy_a, halted_a);
    end
    n_checks++;
    if ({pc_b, ir_b, retired_b, illegal_b, exec_en_b, rd_en_b, busy_b, halted_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got pc=%0h ir=%0h ret=%0d ill=%b ex=%b rd=%b busy=%b halt=%b, want all zero",
               pc_b, ir_b, retired_b, illegal_b, exec_en_b, rd_en_b, busy_b, halted_b);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy_a, rd_en_a, pc_a} !== 10'd0) begin
      n_fail++;
      $display("FAIL idle_hold: got busy=%b rd=%b pc=%0h, want 0 0 0", busy_a, rd_en_a, pc_a);
    end
  endtask

  task automatic test_program();
    logic [31:0] ex_m, rd_m, bz_m;
    kick_a(8'd0);
    trace_a(12, ex_m, rd_m, bz_m);
    n_checks++;
    if (ex_m !== 32'h0000_0090) begin
      n_fail++;
      $display("FAIL prog_exec_cycles: got %h want %h", ex_m, 32'h90);
    end
    n_checks++;
    if (rd_m !== 32'h0000_0124) begin
      n_fail++;
      $display("FAIL prog_fetch_cycles: got %h want %h", rd_m, 32'h124);
    end
    n_checks++;
    if (bz_m !== 32'h0000_03FC) begin
      n_fail++;
      $display("FAIL prog_busy_cycles: got %h want %h", bz_m, 32'h3FC);
    end
    n_checks++;
    if ({halted_a, busy_a, illegal_a, retired_a, pc_a} !== {1'b1, 1'b0, 1'b0, 16'd2, 8'd2}) begin
      n_fail++;
      $display("FAIL prog_end: got halt=%b busy=%b ill=%b ret=%0d pc=%0d want 1 0 0 2 2",
               halted_a, busy_a, illegal_a, retired_a, pc_a);
    end
    n_checks++;
    if (ir_a !== HALT_W) begin
      n_fail++;
      $display("FAIL prog_ir_hold: got %h want %h", ir_a, HALT_W);
    end
  endtask

  task automatic test_mul();
    logic [31:0] ex_m, rd_m, bz_m;
    kick_a(8'd16);
    trace_a(10, ex_m, rd_m, bz_m);
    n_checks++;
    if (ex_m !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL mul_exec_cycles: got %h want %h", ex_m, 32'h40);
    end
    n_checks++;
    if (rd_m !== 32'h0000_0084) begin
      n_fail++;
      $display("FAIL mul_fetch_cycles: got %h want %h", rd_m, 32'h84);
    end
    n_checks++;
    if (bz_m !== 32'h0000_01FC) begin
      n_fail++;
      $display("FAIL mul_busy_cycles: got %h want %h", bz_m, 32'h1FC);
    end
    n_checks++;
    if ({halted_a, retired_a, pc_a} !== {1'b1, 16'd1, 8'd17}) begin
      n_fail++;
      $display("FAIL mul_end: got halt=%b ret=%0d pc=%0d want 1 1 17", halted_a, retired_a, pc_a);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ex_m, rd_m, bz_m;
    kick_a(8'd3);
    trace_a(6, ex_m, rd_m, bz_m);
    n_checks++;
    if ({ex_m, bz_m} !== {32'h0, 32'h0000_000C}) begin
      n_fail++;
      $display("FAIL ill_strobes: got exec=%h busy=%h want exec=0 busy=c", ex_m, bz_m);
    end
    n_checks++;
    if ({illegal_a, halted_a, pc_a, retired_a} !== {1'b1, 1'b1, 8'd3, 16'd0}) begin
      n_fail++;
      $display("FAIL ill_end: got ill=%b halt=%b pc=%0d ret=%0d want 1 1 3 0",
               illegal_a, halted_a, pc_a, retired_a);
    end
    n_checks++;
    if (ir_a !== ILL_W) begin
      n_fail++;
      $display("FAIL ill_ir: got %h want %h", ir_a, ILL_W);
    end
    kick_a(8'd0);
    n_checks++;
    if ({illegal_a, busy_a, halted_a, pc_a} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL ill_restart: got ill=%b busy=%b halt=%b pc=%0d want 0 1 0 0",
               illegal_a, busy_a, halted_a, pc_a);
    end
    trace_a(12, ex_m, rd_m, bz_m);
    n_checks++;
    if ({retired_a, illegal_a} !== {16'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL ill_rerun: got ret=%0d ill=%b want 2 0", retired_a, illegal_a);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] alog[$];
    kick_b(4'd15);
    for (int c = 2; c <= 12; c++) begin
      if (rd_en_b) alog.push_back(addr_b);
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (alog.size() != 2) begin
      n_fail++;
      $display("FAIL wrap_fetch_count: got %0d want 2", alog.size());
    end else begin
      n_checks++;
      if ({alog[0], alog[1]} !== {4'd15, 4'd0}) begin
        n_fail++;
        $display("FAIL wrap_fetch_addr: got %0d,%0d want 15,0", alog[0], alog[1]);
      end
    end
    n_checks++;
    if ({pc_b, retired_b, halted_b, illegal_b} !== {4'd0, 16'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_end: got pc=%0d ret=%0d halt=%b ill=%b want 0 1 1 0",
               pc_b, retired_b, halted_b, illegal_b);
    end
  endtask

  task automatic test_reset_mid_mul();
    kick_a(8'd16);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if ({exec_en_a, busy_a} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmul_pre: got ex=%b busy=%b want 1 1", exec_en_a, busy_a);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pc_a, ir_a, retired_a, illegal_a, exec_en_a, rd_en_a, busy_a, halted_a} !== '0) begin
      n_fail++;
      $display("FAIL rstmul_async: got pc=%0h ir=%0h ret=%0d ill=%b ex=%b rd=%b busy=%b halt=%b, want all zero",
               pc_a, ir_a, retired_a, illegal_a, exec_en_a, rd_en_a, busy_a, halted_a);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({retired_a, busy_a, pc_a, exec_en_a} !== '0) begin
      n_fail++;
      $display("FAIL rstmul_after: got ret=%0d busy=%b pc=%0d ex=%b want 0 0 0 0",
               retired_a, busy_a, pc_a, exec_en_a);
    end
  endtask

  task automatic test_start_while_busy();
    logic [7:0]  alog[$];
    logic [31:0] rd_m;
    rd_m = '0;
    kick_a(8'd0);
    for (int c = 2; c <= 12; c++) begin
      rd_m[c] = rd_en_a;
      if (rd_en_a) alog.push_back(addr_a);
      start_pc_a = 8'd40;
      start_a    = (c == 3) || (c == 5) || (c == 7);
      @(posedge clk);
      #1;
    end
    start_a = 1'b0;
    n_checks++;
    if (rd_m !== 32'h0000_0124) begin
      n_fail++;
      $display("FAIL busy_start_fetch_cycles: got %h want %h", rd_m, 32'h124);
    end
    n_checks++;
    if (alog.size() != 3) begin
      n_fail++;
      $display("FAIL busy_start_fetch_count: got %0d want 3", alog.size());
    end else begin
      n_checks++;
      if ({alog[0], alog[1], alog[2]} !== {8'd0, 8'd1, 8'd2}) begin
        n_fail++;
        $display("FAIL busy_start_addr: got %0d,%0d,%0d want 0,1,2", alog[0], alog[1], alog[2]);
      end
    end
    n_checks++;
    if ({pc_a, retired_a, halted_a} !== {8'd2, 16'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL busy_start_end: got pc=%0d ret=%0d halt=%b want 2 2 1", pc_a, retired_a, halted_a);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = HALT_W;
    for (int i = 0; i < 16; i++) mem_b[i] = HALT_W;
    mem_a[0]  = MOV_W;
    mem_a[1]  = ADD_W;
    mem_a[3]  = ILL_W;
    mem_a[16] = MUL_W;
    mem_b[15] = MOV_W;

    test_reset();
    test_program();
    test_mul();
    test_illegal();
    test_wrap();
    test_reset_mid_mul();
    test_start_while_busy();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
